rice_unary_decoder: RTL and testbench
=====================================

Name: rice_unary_decoder

Overview:
- Parametrised, streaming successor to the 64-bit combinational unary prefix encoder. It finds the Rice quotient, meaning the count of leading zeros before the terminating '1', in MSB-aligned words from the bit-window shifter.
- Unlike the combinational encoder, it accumulates zero-runs that span several words and registers its result.
- It has valid/ready handshakes on both sides, a consume strobe that advances the shifter, and a sticky overflow flag.
- Its quotient output feeds the remainder-extraction stage of the Rice decoder.

Parameters:
- WIDTH, 64, bits per input window; power of two, at least 8.
- QW, 10, quotient width; maximum legal quotient is MAX_Q = 2^QW-1.
- LW, $clog2(WIDTH)+1, consume-length width; must be able to represent WIDTH itself.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- peen  input  1  decode enable; when 0, in_ready=0 and the FSM holds its state.
- in_valid  input  1  in_data is valid.
- in_data  input  WIDTH  MSB-aligned bit window; bit WIDTH-1 is the next stream bit.
- in_ready  output  1  word accepted when in_valid and in_ready are both 1.
- cons_valid  output  1  one-cycle strobe: shifter must advance by cons_len.
- cons_len  output  LW  bits consumed from the accepted word, 1..WIDTH.
- out_valid  output  1  quotient available.
- out_ready  input  1  downstream accepts the quotient.
- q_out  output  QW  decoded quotient, valid while out_valid is 1.
- q_len  output  QW+1  total prefix bits, including the terminating '1', equal to q_out+1.
- ovf  output  1  sticky: the zero-run exceeded MAX_Q.

Behaviour:
- Reset: every output is 0: in_ready, cons_valid, cons_len, out_valid, q_out, q_len, ovf. The accumulator is 0 and the FSM enters SCAN. Reset is effective in any state, including mid-run, and discards a partial run and any held output.
- lz: leading-zero count of in_data, 0..WIDTH, computed combinationally. All-zero input gives lz=WIDTH.
- FSM states:
  - SCAN: acc=0, no output held.
  - RUN: acc>0, a zero-run is in progress.
  - HOLD: out_valid=1, waiting for out_ready.
  - ERR: overflow occurred; the block is dead.
- in_ready is 1 when peen=1 and either the state is SCAN or RUN, or the state is HOLD and out_ready=1 in the same cycle (pass-through with no bubble).
- Accepted word, lz<WIDTH (a '1' is found):
  - Next edge: cons_valid=1, cons_len=lz+1, q_out=acc+lz, q_len=acc+lz+1, out_valid=1, acc cleared, next state HOLD.
  - Latency: one cycle from acceptance to out_valid.
- Accepted word, lz=WIDTH (all zeros):
  - Next edge: cons_valid=1, cons_len=WIDTH, acc=acc+WIDTH, next state RUN, out_valid unchanged.
  - HOLD only accepts a word when out_ready=1, so out_valid is 0 after this edge.
- Arithmetic: acc is QW+1 bits wide. All sums are computed in QW+2 bits before the compare.
- Overflow: if acc+lz > MAX_Q on an accepted word, whether or not a '1' is found:
  - ovf=1, cons_valid=1 with the normal cons_len, out_valid=0, state ERR.
  - ERR: in_ready=0. Only reset leaves ERR.
  - acc+lz = MAX_Q exactly is legal: q_out=MAX_Q, q_len=MAX_Q+1.
- HOLD with out_ready=1 and no new word accepted: out_valid drops at the next edge; state becomes SCAN, or RUN if acc>0 (impossible by construction, but coded anyway).
- Simultaneous handshakes: in HOLD with out_ready=1 and a word accepted, the old quotient retires and the new result (or acc update) takes effect on the same edge.
- q_out and q_len hold their value while out_valid=1 and out_ready=0.
- cons_valid is never 1 for two cycles from a single word. cons_valid=0 on any cycle with no acceptance; cons_len is then don't-care but is driven to 0.
- peen=0 mid-run: acc is retained, and scanning resumes when peen returns to 1. A result already in HOLD may still retire under out_ready.
- in_valid=0: no state change except HOLD retirement.

Decomposition:
- Shared package rice_pkg:
  - FSM state enum: SCAN, RUN, HOLD, ERR.
  - Default WIDTH and QW constants.
  - Function clog2-based LW derivation.
- Sub-module lzc_tree:
  - Parametrised leading-zero counter, WIDTH in, LW out, purely combinational.
  - Log-depth tree replacing the flat casex priority chain.
  - Outputs WIDTH for all-zero input.
  - Reused by the remainder-length stage.

Test Plan:
- WIDTH=64, QW=10: in_data = 64'h8000_0000_0000_0000 accepted -> next cycle cons_len=1, q_out=0, q_len=1, out_valid=1.
- Two words, all-zero then 64'h0000_0000_0000_0400: the first gives cons_len=64 and no out_valid; the second gives cons_len=54, q_out=117, q_len=118.
- out_ready held 0 for 5 cycles with a pending result -> in_ready=0 and q_out stable. When out_ready=1 with in_valid=1 (in_data=64'h2000_0000_0000_0000) -> same-edge retire, next q_out=2.
- 15 all-zero words then 64'h4000_0000_0000_0000 (MAX_Q=1023): acc reaches 960, q_out=961. Then 16 all-zero words: acc+lz=1024 > 1023 -> ovf=1, in_ready stays 0 until reset.
- reset asserted in RUN with acc=128 -> all outputs 0 next cycle. A following word 64'h1000_0000_0000_0000 gives q_out=3, not 131.
- Sweep lz=0..63 with WIDTH=16 and WIDTH=64 against a reference model; peen toggled randomly -> no acceptance while peen=0, and acc is preserved.

Source files
------------

// File: rtl/rice_pkg.sv
// Shared types and defaults for the Rice unary (quotient) decoder and its
// leading-zero counter.
package rice_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_QW    = 10;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Consume-length width: must hold the value WIDTH itself.
  function automatic int lw_of(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Log-depth leading-zero counter. Bit WIDTH-1 is the first stream bit; an
// all-zero word reports WIDTH.
module lzc_tree #(
  parameter int WIDTH = 64,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] in_data,
  output logic [LW-1:0]    lz,
  output logic             all_zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // Node i of level l covers 2**l bits; node 0 is the MSB-most span.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [LW-1:0] cnt  [N];
    logic          zero [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_n
        assign zero[i] = ~in_data[WIDTH-1-i];
        assign cnt[i]  = {{(LW-1){1'b0}}, ~in_data[WIDTH-1-i]};
      end
    end else begin : g_node
      localparam int SPAN = 1 << (l - 1);
      for (genvar i = 0; i < N; i++) begin : g_n
        assign zero[i] = g_lvl[l-1].zero[2*i] & g_lvl[l-1].zero[2*i+1];
        assign cnt[i]  = g_lvl[l-1].zero[2*i]
                         ? LW'(SPAN) + g_lvl[l-1].cnt[2*i+1]
                         : g_lvl[l-1].cnt[2*i];
      end
    end
  end

  assign lz       = g_lvl[LEVELS].cnt[0];
  assign all_zero = g_lvl[LEVELS].zero[0];

endmodule

// File: rtl/rice_unary_decoder.sv
// Streaming Rice quotient decoder: counts leading zeros across consecutive
// MSB-aligned windows until the terminating '1', then presents the quotient.
module rice_unary_decoder
  import rice_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int QW    = DEF_QW,
  parameter int LW    = lw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             peen,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             cons_valid,
  output logic [LW-1:0]    cons_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    q_out,
  output logic [QW:0]      q_len,
  output logic             ovf,
  output state_e           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on valid of the same interface.

  localparam logic [QW+1:0] MAX_Q = {2'b00, {QW{1'b1}}};

  state_e        state_q, state_d;
  logic [QW:0]   acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [QW-1:0] q_out_q, q_out_d;
  logic [QW:0]   q_len_q, q_len_d;
  logic          cons_valid_q, cons_valid_d;
  logic [LW-1:0] cons_len_q, cons_len_d;
  logic          ovf_q, ovf_d;

  logic [LW-1:0] lz;
  logic          all_zero;
  logic          accept;
  logic [QW+1:0] sum;

  lzc_tree #(.WIDTH(WIDTH), .LW(LW)) u_lzc (
    .in_data  (in_data),
    .lz       (lz),
    .all_zero (all_zero)
  );

  assign in_ready = ~reset & peen &
                    ((state_q == SCAN) || (state_q == RUN) ||
                     ((state_q == HOLD) && out_ready));
  assign accept   = in_valid & in_ready;
  assign sum      = {1'b0, acc_q} + (QW+2)'(lz);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    q_out_d      = q_out_q;
    q_len_d      = q_len_q;
    cons_valid_d = 1'b0;
    cons_len_d   = '0;
    ovf_d        = ovf_q;

    if ((state_q == HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = (acc_q != '0) ? RUN : SCAN;
    end

    // A new word overrides the retirement outcome on the same edge.
    if (accept) begin
      cons_valid_d = 1'b1;
      cons_len_d   = all_zero ? LW'(WIDTH) : lz + LW'(1);
      if (sum > MAX_Q) begin
        ovf_d       = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ERR;
      end else if (!all_zero) begin
        q_out_d     = sum[QW-1:0];
        q_len_d     = sum[QW:0] + (QW+1)'(1);
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = HOLD;
      end else begin
        acc_d   = sum[QW:0];
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      q_out_q      <= '0;
      q_len_q      <= '0;
      cons_valid_q <= 1'b0;
      cons_len_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      q_out_q      <= q_out_d;
      q_len_q      <= q_len_d;
      cons_valid_q <= cons_valid_d;
      cons_len_q   <= cons_len_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign q_out      = q_out_q;
  assign q_len      = q_len_q;
  assign cons_valid = cons_valid_q;
  assign cons_len   = cons_len_q;
  assign ovf        = ovf_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rice_unary_decoder.sv
// Scoreboard bench for rice_unary_decoder at WIDTH=64 and WIDTH=16 (QW=10).
module tb_rice_unary_decoder;
  import rice_pkg::*;

  localparam int QW   = 10;
  localparam int MAXQ = (1 << QW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_peen, a_in_valid, a_in_ready, a_cons_valid, a_out_valid, a_out_ready, a_ovf;
  logic [63:0]   a_in_data;
  logic [6:0]    a_cons_len;
  logic [QW-1:0] a_q_out;
  logic [QW:0]   a_q_len;
  state_e        a_state;

  logic          b_peen, b_in_valid, b_in_ready, b_cons_valid, b_out_valid, b_out_ready, b_ovf;
  logic [15:0]   b_in_data;
  logic [4:0]    b_cons_len;
  logic [QW-1:0] b_q_out;
  logic [QW:0]   b_q_len;
  state_e        b_state;

  rice_unary_decoder #(.WIDTH(64), .QW(QW)) dut_a (
    .clk(clk), .reset(reset), .peen(a_peen), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .cons_valid(a_cons_valid), .cons_len(a_cons_len),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .q_out(a_q_out), .q_len(a_q_len),
    .ovf(a_ovf), .state_dbg(a_state)
  );

  rice_unary_decoder #(.WIDTH(16), .QW(QW)) dut_b (
    .clk(clk), .reset(reset), .peen(b_peen), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .cons_valid(b_cons_valid), .cons_len(b_cons_len),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .q_out(b_q_out), .q_len(b_q_len),
    .ovf(b_ovf), .state_dbg(b_state)
  );

  int total = 0;
  int bad   = 0;

  logic [QW:0] a_exp_q[$];
  logic [QW:0] b_exp_q[$];
  logic [6:0]  a_cons_q[$];
  logic [6:0]  b_cons_q[$];

  // Reference model: run length so far, quotient pending downstream, dead.
  int m_acc  [2];
  bit m_hold [2];
  bit m_dead [2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand_word(input int lz, input int w);
    logic [63:0] one, mask;
    one  = 64'd1 << (w - 1 - lz);
    mask = one - 64'd1;
    return one | ({$urandom, $urandom} & mask);
  endfunction

  function automatic void model_word(input int id, input logic [63:0] d);
    int w, lz, sum, cl;
    w  = (id == 0) ? 64 : 16;
    lz = w;
    for (int i = 0; i < w; i++) if (d[i]) lz = w - 1 - i;
    cl = (lz == w) ? w : lz + 1;
    if (id == 0) a_cons_q.push_back(7'(cl)); else b_cons_q.push_back(7'(cl));
    sum = m_acc[id] + lz;
    if (sum > MAXQ) begin
      m_dead[id] = 1'b1;
      m_hold[id] = 1'b0;
    end else if (lz < w) begin
      if (id == 0) a_exp_q.push_back((QW+1)'(sum)); else b_exp_q.push_back((QW+1)'(sum));
      m_hold[id] = 1'b1;
      m_acc[id]  = 0;
    end else begin
      m_acc[id] = sum;
    end
  endfunction

  // One clock of stimulus on one DUT; checks the state left by the previous edge.
  task automatic step(input int id, input bit v, input logic [63:0] d, input bit pe, input bit ordy);
    bit rdy_exp;
    @(posedge clk); #1;
    if (id == 0) begin
      chk("a_out_valid", a_out_valid, m_hold[0]);
      chk("a_ovf", a_ovf, m_dead[0]);
      a_in_valid = v; a_in_data = d; a_peen = pe; a_out_ready = ordy;
    end else begin
      chk("b_out_valid", b_out_valid, m_hold[1]);
      chk("b_ovf", b_ovf, m_dead[1]);
      b_in_valid = v; b_in_data = d[15:0]; b_peen = pe; b_out_ready = ordy;
    end
    #1;
    rdy_exp = pe && !m_dead[id] && (!m_hold[id] || ordy);
    if (id == 0) chk("a_in_ready", a_in_ready, rdy_exp);
    else         chk("b_in_ready", b_in_ready, rdy_exp);
    if (m_hold[id] && ordy) m_hold[id] = 1'b0;
    if (v && rdy_exp) model_word(id, d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    a_peen = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_peen = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("a_rst_in_ready", a_in_ready, 0);    chk("b_rst_in_ready", b_in_ready, 0);
    chk("a_rst_cons_valid", a_cons_valid, 0); chk("b_rst_cons_valid", b_cons_valid, 0);
    chk("a_rst_cons_len", a_cons_len, 0);     chk("b_rst_cons_len", b_cons_len, 0);
    chk("a_rst_out_valid", a_out_valid, 0);   chk("b_rst_out_valid", b_out_valid, 0);
    chk("a_rst_q_out", a_q_out, 0);           chk("b_rst_q_out", b_q_out, 0);
    chk("a_rst_q_len", a_q_len, 0);           chk("b_rst_q_len", b_q_len, 0);
    chk("a_rst_ovf", a_ovf, 0);               chk("b_rst_ovf", b_ovf, 0);
    chk("a_cons_drain", a_cons_q.size(), 0);  chk("b_cons_drain", b_cons_q.size(), 0);
    a_cons_q.delete(); b_cons_q.delete(); a_exp_q.delete(); b_exp_q.delete();
    for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_hold[i] = 1'b0; m_dead[i] = 1'b0; end
    reset = 1'b0;
  endtask

  // Monitors: pop on every consume strobe and every output handshake.
  always @(negedge clk) begin
    if (a_cons_valid === 1'b1) begin
      if (a_cons_q.size() == 0) chk("a_cons_spurious", 1, 0);
      else chk("a_cons_len", a_cons_len, a_cons_q.pop_front());
    end
    if (a_out_valid === 1'b1) begin
      if (a_exp_q.size() == 0) chk("a_q_spurious", 1, 0);
      else begin
        chk("a_q_out", a_q_out, a_exp_q[0]);
        chk("a_q_len", a_q_len, a_exp_q[0] + 1);
        if (a_out_ready === 1'b1) void'(a_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_cons_valid === 1'b1) begin
      if (b_cons_q.size() == 0) chk("b_cons_spurious", 1, 0);
      else chk("b_cons_len", b_cons_len, b_cons_q.pop_front());
    end
    if (b_out_valid === 1'b1) begin
      if (b_exp_q.size() == 0) chk("b_q_spurious", 1, 0);
      else begin
        chk("b_q_out", b_q_out, b_exp_q[0]);
        chk("b_q_len", b_q_len, b_exp_q[0] + 1);
        if (b_out_ready === 1'b1) void'(b_exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_peen = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_peen = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    do_reset();

    // First-bit hit, then a held result with back-pressure and same-edge retire.
    step(0, 1, 64'h8000_0000_0000_0000, 1, 0);
    repeat (5) step(0, 1, 64'h2000_0000_0000_0000, 1, 0);
    step(0, 1, 64'h2000_0000_0000_0000, 1, 1);
    step(0, 0, 64'd0, 1, 1);

    // Run spanning two words: 64 + 53 = 117.
    step(0, 1, 64'd0, 1, 1);
    step(0, 1, 64'h0000_0000_0000_0400, 1, 1);
    step(0, 0, 64'd0, 1, 1);

    // 960 + 1 = 961, then a run of 1024 overflows.
    repeat (15) step(0, 1, 64'd0, 1, 1);
    step(0, 1, 64'h4000_0000_0000_0000, 1, 1);
    step(0, 0, 64'd0, 1, 1);
    repeat (16) step(0, 1, 64'd0, 1, 1);
    repeat (3) step(0, 1, 64'h8000_0000_0000_0000, 1, 1);

    // Reset mid-run discards acc=128.
    do_reset();
    repeat (2) step(0, 1, 64'd0, 1, 1);
    do_reset();
    step(0, 1, 64'h1000_0000_0000_0000, 1, 1);
    step(0, 0, 64'd0, 1, 1);

    // Exactly MAX_Q is legal.
    repeat (15) step(0, 1, 64'd0, 1, 1);
    step(0, 1, 64'h0000_0000_0000_0001, 1, 1);
    step(0, 0, 64'd0, 1, 1);

    // peen low mid-run keeps the accumulated run.
    repeat (2) step(0, 1, 64'd0, 1, 1);
    repeat (3) step(0, 1, 64'h0400_0000_0000_0000, 0, 1);
    step(0, 1, 64'h0400_0000_0000_0000, 1, 1);
    step(0, 0, 64'd0, 1, 1);

    for (int lz = 0; lz < 64; lz++) step(0, 1, rand_word(lz, 64), 1, 1);

    for (int n = 0; n < 300; n++) begin
      if (m_dead[0]) do_reset();
      step(0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? 64'd0 : rand_word($urandom_range(0, 63), 64),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) step(0, 0, 64'd0, 1, 1);

    for (int lz = 0; lz < 16; lz++) step(1, 1, rand_word(lz, 16), 1, 1);
    repeat (2) step(1, 1, 64'd0, 1, 1);
    step(1, 1, 64'h0000_0000_0000_0100, 1, 1);
    for (int n = 0; n < 300; n++) begin
      if (m_dead[1]) do_reset();
      step(1, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 2) == 0) ? 64'd0 : rand_word($urandom_range(0, 15), 16),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) step(1, 0, 64'd0, 1, 1);

    @(negedge clk);
    chk("a_exp_left", a_exp_q.size(), 0);
    chk("a_cons_left", a_cons_q.size(), 0);
    chk("b_exp_left", b_exp_q.size(), 0);
    chk("b_cons_left", b_cons_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
